// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common-data-bus arbiter with per-source result FIFOs
// Optional same-cycle bypass of empty FIFOs with CDB_BYPASS_EN.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module cdb_arbiter #(
    parameter int ROB_W  = `ROB_SIZE_WIDTH,
    parameter int QDEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             need_flush_in,
    input  logic             alu_valid,
    input  logic [31:0]      alu_value,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic             mem_valid,
    input  logic [31:0]      mem_value,
    input  logic [ROB_W-1:0] mem_rob_id,
    output logic             alu_full,
    output logic             mem_full,
    output logic             cdb_valid,
    output logic [31:0]      cdb_value,
    output logic [ROB_W-1:0] cdb_rob_id,
    output logic             cdb_src
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    // Source index 0 is the ALU, 1 is the memory unit.
    logic [1:0]       in_valid;
    logic [31:0]      in_value [2];
    logic [ROB_W-1:0] in_id    [2];

    assign in_valid    = {mem_valid, alu_valid};
    assign in_value[0] = alu_value;
    assign in_value[1] = mem_value;
    assign in_id[0]    = alu_rob_id;
    assign in_id[1]    = mem_rob_id;

    logic [31:0]      q_value [2][QDEPTH];
    logic [ROB_W-1:0] q_id    [2][QDEPTH];
    logic [PW-1:0]    rd_ptr  [2];
    logic [PW-1:0]    wr_ptr  [2];
    logic [CW-1:0]    count   [2];
    logic             last_grant;

    logic [1:0]       full;
    logic [1:0]       head_ok;
    logic [1:0]       cand;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             grant_any;
    logic             grant_src;
    logic [31:0]      win_value;
    logic [ROB_W-1:0] win_id;
    logic             active;

    assign active   = rdy_in && !need_flush_in;
    assign alu_full = full[0];
    assign mem_full = full[1];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            full[s]    = (count[s] == DEPTH_C);
            head_ok[s] = (count[s] != '0);
`ifdef CDB_BYPASS_EN
            cand[s]    = head_ok[s] || in_valid[s];
`else
            cand[s]    = head_ok[s];
`endif
        end

        grant_any = |cand;
        if (cand[0] && cand[1]) grant_src = ~last_grant;
        else                    grant_src = cand[1];

        win_value = q_value[grant_src][rd_ptr[grant_src]];
        win_id    = q_id[grant_src][rd_ptr[grant_src]];
`ifdef CDB_BYPASS_EN
        // An empty-FIFO winner must be the live input.
        if (!head_ok[grant_src]) begin
            win_value = in_value[grant_src];
            win_id    = in_id[grant_src];
        end
`endif

        for (int s = 0; s < 2; s++) begin
            pop[s]  = active && grant_any && (grant_src == 1'(s)) && head_ok[s];
            push[s] = active && in_valid[s] && !full[s];
`ifdef CDB_BYPASS_EN
            if (grant_any && (grant_src == 1'(s)) && !head_ok[s]) push[s] = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
            last_grant <= 1'b1;
            cdb_valid  <= 1'b0;
            cdb_value  <= '0;
            cdb_rob_id <= '0;
            cdb_src    <= 1'b0;
        end else if (!rdy_in) begin
            cdb_valid <= 1'b0;
        end else if (need_flush_in) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
            last_grant <= 1'b1;
            cdb_valid  <= 1'b0;
        end else begin
            cdb_valid <= grant_any;
            if (grant_any) begin
                cdb_value  <= win_value;
                cdb_rob_id <= win_id;
                cdb_src    <= grant_src;
                last_grant <= grant_src;
            end
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
                if (push[s] && !pop[s])      count[s] <= count[s] + CW'(1);
                else if (!push[s] && pop[s]) count[s] <= count[s] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                q_value[s][wr_ptr[s]] <= in_value[s];
                q_id[s][wr_ptr[s]]    <= in_id[s];
            end
        end
    end
endmodule
